// File: rtl/sa_matrix_feeder.sv
// sa_matrix_feeder: bit-matrix store that streams rows to a systolic array and returns its rank result
module sa_matrix_feeder #(
    parameter int DAT_W   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     wr_en,
    input  logic [$clog2(DAT_W)-1:0] wr_addr,
    input  logic [DAT_W-1:0]         wr_data,
    input  logic                     go,
    output logic                     busy,
    output logic                     sa_start,
    output logic [DAT_W-1:0]         sa_data,
    input  logic                     sa_finish,
    input  logic                     sa_full_rank,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_full_rank,
    output logic                     res_timeout
);
    localparam int AW = $clog2(DAT_W);
    localparam int CW = $clog2(DAT_W + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;
    state_t                           state_q, state_d;
    logic [DAT_W-1:0][DAT_W-1:0]      mem_q, mem_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [WW-1:0]                    wcnt_q, wcnt_d;
    logic                             sa_start_q, sa_start_d;
    logic [DAT_W-1:0]                 sa_data_q, sa_data_d;
    logic                             res_fr_q, res_fr_d;
    logic                             res_to_q, res_to_d;
    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        sa_start_d = sa_start_q;
        sa_data_d  = sa_data_q;
        res_fr_d   = res_fr_q;
        res_to_d   = res_to_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d    = STREAM;
                    sa_start_d = 1'b1;
                    sa_data_d  = mem_q[0];
                    cnt_d      = CW'(1);
                end else if (wr_en && int'(wr_addr) < DAT_W) begin
                    mem_d[wr_addr] = wr_data;
                end
            end
            STREAM: begin
                sa_start_d = 1'b0;
                if (cnt_q == CW'(DAT_W)) begin
                    sa_data_d = '0;
                    state_d   = WAIT;
                    wcnt_d    = '0;
                end else begin
                    sa_data_d = mem_q[cnt_q[AW-1:0]];
                    cnt_d     = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                // finish wins over a coincident timeout
                if (sa_finish) begin
                    res_fr_d = sa_full_rank;
                    res_to_d = 1'b0;
                    state_d  = DONE;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    res_fr_d = 1'b0;
                    res_to_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            DONE: state_d = res_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            mem_q      <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            sa_start_q <= 1'b0;
            sa_data_q  <= '0;
            res_fr_q   <= 1'b0;
            res_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            sa_start_q <= sa_start_d;
            sa_data_q  <= sa_data_d;
            res_fr_q   <= res_fr_d;
            res_to_q   <= res_to_d;
        end
    end
    assign busy          = state_q != IDLE;
    assign sa_start      = sa_start_q;
    assign sa_data       = sa_data_q;
    assign res_valid     = state_q == DONE;
    assign res_full_rank = res_fr_q;
    assign res_timeout   = res_to_q;
endmodule

// File: tb/tb_sa_matrix_feeder.sv
// tb_sa_matrix_feeder: directed checks of row streaming, result handshake, timeout and reset
module tb_sa_matrix_feeder;
    localparam int DAT_W   = 4;
    localparam int TIMEOUT = 32;
    logic             clk = 0;
    logic             rst_b = 0;
    logic             wr_en = 0;
    logic [1:0]       wr_addr = 0;
    logic [DAT_W-1:0] wr_data = 0;
    logic             go = 0;
    logic             busy, sa_start, res_valid, res_full_rank, res_timeout;
    logic [DAT_W-1:0] sa_data;
    logic             sa_finish = 0, sa_full_rank = 0, res_ready = 0;
    int               checks = 0, errors = 0;
    sa_matrix_feeder #(.DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .busy(busy), .sa_start(sa_start), .sa_data(sa_data),
        .sa_finish(sa_finish), .sa_full_rank(sa_full_rank), .res_valid(res_valid),
        .res_ready(res_ready), .res_full_rank(res_full_rank), .res_timeout(res_timeout)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask
    task automatic zero_outs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_start"}, sa_start, 0);
        check({tag, "_data"}, sa_data, 0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_fr"}, res_full_rank, 0);
        check({tag, "_to"}, res_timeout, 0);
    endtask
    task automatic stream(input logic [15:0] rows, input logic noisy, input logic clash);
        go = 1;
        if (clash) begin wr_en = 1; wr_addr = 0; wr_data = 4'hf; end
        tick();
        wr_en = 0;
        go = noisy;
        for (int i = 0; i < 4; i++) begin
            check("start", sa_start, i == 0);
            check("row", sa_data, rows[15-4*i -: 4]);
            if (i < 3) tick();
        end
        tick();
        check("tail", sa_data, 0);
        check("wait_busy", busy, 1);
    endtask
    task automatic finish_run(input logic fr);
        sa_finish = 1; sa_full_rank = fr;
        tick();
        sa_finish = 0; sa_full_rank = 0;
        check("fin_valid", res_valid, 1);
        check("fin_fr", res_full_rank, fr);
        check("fin_to", res_timeout, 0);
    endtask
    task automatic accept();
        res_ready = 1;
        tick();
        res_ready = 0;
        check("acc_valid", res_valid, 0);
        check("acc_busy", busy, 0);
    endtask
    initial begin
        #12;
        zero_outs("rst");
        rst_b = 1;
        tick();
        // identity matrix, full rank
        wr(0, 4'h8); wr(1, 4'h4); wr(2, 4'h2); wr(3, 4'h1);
        sa_finish = 1; sa_full_rank = 1;
        tick();
        sa_finish = 0; sa_full_rank = 0;
        check("idle_finish_ignored", res_valid, 0);
        stream(16'h8421, 0, 0);
        finish_run(1);
        accept();
        // rank-deficient matrix, consumer stalls
        wr(0, 4'hc); wr(1, 4'hc); wr(2, 4'h3); wr(3, 4'h1);
        stream(16'hcc31, 0, 0);
        finish_run(0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", res_valid, 1);
            check("stall_fr", res_full_rank, 0);
        end
        accept();
        // timeout with sa_full_rank noise
        stream(16'hcc31, 0, 0);
        sa_full_rank = 1;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("to_early", res_valid, 0);
        tick();
        sa_full_rank = 0;
        check("to_valid", res_valid, 1);
        check("to_flag", res_timeout, 1);
        check("to_fr", res_full_rank, 0);
        accept();
        // finish coinciding with the timeout limit
        stream(16'hcc31, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        finish_run(1);
        accept();
        // go held through STREAM/WAIT plus a write during WAIT
        wr(0, 4'h8); wr(1, 4'h4); wr(2, 4'h2); wr(3, 4'h1);
        stream(16'h8421, 1, 0);
        wr_en = 1; wr_addr = 0; wr_data = 4'h0;
        tick();
        tick();
        check("noisy_start", sa_start, 0);
        check("noisy_busy", busy, 1);
        wr_en = 0; go = 0;
        finish_run(1);
        accept();
        stream(16'h8421, 0, 0);
        finish_run(1);
        accept();
        // reset in the second STREAM row
        go = 1;
        tick();
        go = 0;
        tick();
        check("pre_rst_row1", sa_data, 4'h4);
        #2 rst_b = 0;
        #1 zero_outs("mid_rst");
        @(negedge clk);
        rst_b = 1;
        tick();
        tick();
        check("post_rst_start", sa_start, 0);
        check("post_rst_busy", busy, 0);
        stream(16'h0000, 0, 0);
        finish_run(0);
        accept();
        // go and a write to row 0 in the same cycle
        wr(0, 4'h5);
        stream(16'h5000, 0, 1);
        finish_run(1);
        accept();
        stream(16'h5000, 0, 0);
        finish_run(1);
        accept();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
